// File: rtl/decode_stage.sv
// RV32I/RV64I decode stage: combinational decode of i_instr captured into a
// 2-entry skid buffer with valid/ready on both sides, flush and sync reset.
module decode_stage #(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [31:0]     i_instr,
  input  logic [XLEN-1:0] i_pc,
  input  logic            i_flush,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [31:0]     o_instr,
  output logic [XLEN-1:0] o_pc,
  output logic [2:0]      o_immsrc,
  output logic [XLEN-1:0] o_imm,
  output logic [4:0]      o_rd,
  output logic [4:0]      o_rs1,
  output logic [4:0]      o_rs2,
  output logic [2:0]      o_funct3,
  output logic            o_regwrite,
  output logic            o_memwrite,
  output logic [1:0]      o_resultsrc,
  output logic            o_alusrc,
  output logic            o_branch,
  output logic            o_jump,
  output logic            o_illegal,
  output logic [1:0]      o_state
);

  // Handshake: a transfer happens on a rising edge where valid && ready are
  // both high; valid never waits on ready, and ready here is a registered flop.
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_e;

  typedef struct packed {
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
    logic [2:0]      immsrc;
    logic [XLEN-1:0] imm;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [2:0]      funct3;
    logic            regwrite;
    logic            memwrite;
    logic [1:0]      resultsrc;
    logic            alusrc;
    logic            branch;
    logic            jump;
    logic            illegal;
  } entry_t;

  localparam entry_t RST_ENTRY = '{immsrc: 3'b011, default: '0};

  state_e state_q, state_d;
  entry_t head_q, head_d, tail_q, tail_d;
  logic   ready_q, ready_d;
  entry_t dec;
  logic [31:0] imm32;
  logic accept, pop;

  always_comb begin
    dec        = '0;
    dec.instr  = i_instr;
    dec.pc     = i_pc;
    dec.rd     = i_instr[11:7];
    dec.rs1    = i_instr[19:15];
    dec.rs2    = i_instr[24:20];
    dec.funct3 = i_instr[14:12];
    dec.immsrc = 3'b011;
    case (i_instr[6:0])
      7'b0000011: begin dec.immsrc = 3'b000; dec.regwrite = 1'b1; dec.resultsrc = 2'b01; dec.alusrc = 1'b1; end
      7'b0010011: begin dec.immsrc = 3'b000; dec.regwrite = 1'b1; dec.alusrc = 1'b1; end
      7'b1100111: begin
        if (i_instr[14:12] == 3'b000) begin
          dec.immsrc = 3'b000; dec.regwrite = 1'b1; dec.resultsrc = 2'b10;
          dec.alusrc = 1'b1; dec.jump = 1'b1;
        end else begin
          dec.illegal = 1'b1;
        end
      end
      7'b0100011: begin dec.immsrc = 3'b001; dec.memwrite = 1'b1; dec.alusrc = 1'b1; end
      7'b1100011: begin dec.immsrc = 3'b010; dec.branch = 1'b1; end
      7'b0110011: begin dec.immsrc = 3'b011; dec.regwrite = 1'b1; end
      7'b0110111,
      7'b0010111: begin dec.immsrc = 3'b100; dec.regwrite = 1'b1; dec.alusrc = 1'b1; end
      7'b1101111: begin dec.immsrc = 3'b101; dec.regwrite = 1'b1; dec.resultsrc = 2'b10; dec.jump = 1'b1; end
      default:    dec.illegal = 1'b1;
    endcase

    // Build a 32-bit immediate, then sign-extend from bit 31 to XLEN.
    case (dec.immsrc)
      3'b000:  imm32 = {{20{i_instr[31]}}, i_instr[31:20]};
      3'b001:  imm32 = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
      3'b010:  imm32 = {{20{i_instr[31]}}, i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0};
      3'b100:  imm32 = {i_instr[31:12], 12'b0};
      3'b101:  imm32 = {{12{i_instr[31]}}, i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0};
      default: imm32 = 32'b0;
    endcase
    dec.imm = XLEN'($signed(imm32));
  end

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    accept  = i_valid && ready_q;
    pop     = (state_q != EMPTY) && i_ready;
    // Flush drops any same-cycle accept; a same-cycle pop has already left.
    if (i_flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: if (accept) begin head_d = dec; state_d = ONE; end
        ONE: begin
          if (accept && pop)  head_d = dec;
          else if (accept)    begin tail_d = dec; state_d = TWO; end
          else if (pop)       state_d = EMPTY;
        end
        TWO: if (pop) begin head_d = tail_q; state_d = ONE; end
        default: state_d = EMPTY;
      endcase
    end
    ready_d = (state_d != TWO);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= EMPTY;
      ready_q <= 1'b1;
      head_q  <= RST_ENTRY;
      tail_q  <= RST_ENTRY;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

  assign o_ready     = ready_q;
  assign o_valid     = (state_q != EMPTY);
  assign o_state     = state_q;
  assign o_instr     = head_q.instr;
  assign o_pc        = head_q.pc;
  assign o_immsrc    = head_q.immsrc;
  assign o_imm       = head_q.imm;
  assign o_rd        = head_q.rd;
  assign o_rs1       = head_q.rs1;
  assign o_rs2       = head_q.rs2;
  assign o_funct3    = head_q.funct3;
  assign o_regwrite  = head_q.regwrite;
  assign o_memwrite  = head_q.memwrite;
  assign o_resultsrc = head_q.resultsrc;
  assign o_alusrc    = head_q.alusrc;
  assign o_branch    = head_q.branch;
  assign o_jump      = head_q.jump;
  assign o_illegal   = head_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: decode table, immediates (XLEN 32 and 64),
// skid-buffer backpressure, flush, illegal encodings and mid-transfer reset.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst, in_valid, flush, out_ready;
  logic [31:0] instr, pc;

  logic        o_ready, o_valid, o_regwrite, o_memwrite, o_alusrc, o_branch, o_jump, o_illegal;
  logic [31:0] o_instr, o_pc, o_imm;
  logic [2:0]  o_immsrc, o_funct3;
  logic [4:0]  o_rd, o_rs1, o_rs2;
  logic [1:0]  o_resultsrc, o_state;

  logic        w_ready, w_valid, w_regwrite, w_memwrite, w_alusrc, w_branch, w_jump, w_illegal;
  logic [31:0] w_instr;
  logic [63:0] w_pc, w_imm;
  logic [2:0]  w_immsrc, w_funct3;
  logic [4:0]  w_rd, w_rs1, w_rs2;
  logic [1:0]  w_resultsrc, w_state;

  int n_pass = 0;
  int n_total = 0;
  logic [31:0] exp_q[$];

  decode_stage #(.XLEN(32)) dut (
    .i_clk(clk), .i_rst(rst), .i_valid(in_valid), .o_ready(o_ready),
    .i_instr(instr), .i_pc(pc), .i_flush(flush), .o_valid(o_valid),
    .i_ready(out_ready), .o_instr(o_instr), .o_pc(o_pc), .o_immsrc(o_immsrc),
    .o_imm(o_imm), .o_rd(o_rd), .o_rs1(o_rs1), .o_rs2(o_rs2), .o_funct3(o_funct3),
    .o_regwrite(o_regwrite), .o_memwrite(o_memwrite), .o_resultsrc(o_resultsrc),
    .o_alusrc(o_alusrc), .o_branch(o_branch), .o_jump(o_jump), .o_illegal(o_illegal),
    .o_state(o_state)
  );

  decode_stage #(.XLEN(64)) dut64 (
    .i_clk(clk), .i_rst(rst), .i_valid(in_valid), .o_ready(w_ready),
    .i_instr(instr), .i_pc({32'b0, pc}), .i_flush(flush), .o_valid(w_valid),
    .i_ready(out_ready), .o_instr(w_instr), .o_pc(w_pc), .o_immsrc(w_immsrc),
    .o_imm(w_imm), .o_rd(w_rd), .o_rs1(w_rs1), .o_rs2(w_rs2), .o_funct3(w_funct3),
    .o_regwrite(w_regwrite), .o_memwrite(w_memwrite), .o_resultsrc(w_resultsrc),
    .o_alusrc(w_alusrc), .o_branch(w_branch), .o_jump(w_jump), .o_illegal(w_illegal),
    .o_state(w_state)
  );

  // Clock and reset
  always #5 clk = ~clk;

  // Driver tasks: inputs change 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] p);
    in_valid = v;
    instr    = ins;
    pc       = p;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Scoreboard: every accepted instruction must pop out in order, once.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      if (o_valid && out_ready) begin
        if (exp_q.size() == 0) chk("sb_unexpected_pop", 64'(o_instr), 64'hDEAD);
        else chk("sb_order", 64'(o_instr), 64'(exp_q.pop_front()));
      end
      if (flush) exp_q.delete();
      else if (in_valid && o_ready) exp_q.push_back(instr);
    end
  end

  initial begin
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    tick(); tick();
    chk("rst_valid",  64'(o_valid), 64'd0);
    chk("rst_ready",  64'(o_ready), 64'd1);
    chk("rst_immsrc", 64'(o_immsrc), 64'd3);
    chk("rst_imm",    64'(o_imm), 64'd0);
    chk("rst_instr",  64'(o_instr), 64'd0);
    chk("rst_pc",     64'(o_pc), 64'd0);
    rst = 1'b0;

    // Load lw x5,8(x2)
    out_ready = 1'b1;
    drive(1'b1, 32'h00812283, 32'h100);
    tick();
    drive(1'b0, 32'h0, 32'h0);
    chk("ld_valid",     64'(o_valid), 64'd1);
    chk("ld_immsrc",    64'(o_immsrc), 64'd0);
    chk("ld_imm",       64'(o_imm), 64'd8);
    chk("ld_rd",        64'(o_rd), 64'd5);
    chk("ld_rs1",       64'(o_rs1), 64'd2);
    chk("ld_regwrite",  64'(o_regwrite), 64'd1);
    chk("ld_resultsrc", 64'(o_resultsrc), 64'd1);
    chk("ld_alusrc",    64'(o_alusrc), 64'd1);
    chk("ld_pc",        64'(o_pc), 64'h100);

    // Store sw x5,-4(x2)
    drive(1'b1, 32'hFE512E23, 32'h104);
    tick();
    drive(1'b0, 32'h0, 32'h0);
    chk("st_immsrc",   64'(o_immsrc), 64'd1);
    chk("st_imm",      64'(o_imm), 64'hFFFFFFFC);
    chk("st_rs2",      64'(o_rs2), 64'd5);
    chk("st_memwrite", 64'(o_memwrite), 64'd1);
    chk("st_regwrite", 64'(o_regwrite), 64'd0);

    // Branch beq x0,x0,-8
    drive(1'b1, 32'hFE000CE3, 32'h108);
    tick();
    drive(1'b0, 32'h0, 32'h0);
    chk("br_immsrc", 64'(o_immsrc), 64'd2);
    chk("br_imm",    64'(o_imm), 64'hFFFFFFF8);
    chk("br_branch", 64'(o_branch), 64'd1);
    chk("br_imm64",  w_imm, 64'hFFFFFFFFFFFFFFF8);

    // Illegal all-zero word
    drive(1'b1, 32'h00000000, 32'h10C);
    tick();
    drive(1'b0, 32'h0, 32'h0);
    chk("il0_illegal", 64'(o_illegal), 64'd1);
    chk("il0_immsrc",  64'(o_immsrc), 64'd3);
    chk("il0_imm",     64'(o_imm), 64'd0);
    chk("il0_enables", 64'({o_regwrite, o_memwrite, o_alusrc, o_branch, o_jump, o_resultsrc}), 64'd0);

    // JALR with funct3=001 is illegal
    drive(1'b1, 32'h00809067, 32'h110);
    tick();
    drive(1'b0, 32'h0, 32'h0);
    chk("il1_illegal", 64'(o_illegal), 64'd1);
    chk("il1_immsrc",  64'(o_immsrc), 64'd3);
    chk("il1_imm",     64'(o_imm), 64'd0);
    chk("il1_enables", 64'({o_regwrite, o_memwrite, o_alusrc, o_branch, o_jump, o_resultsrc}), 64'd0);

    // jal x1,8 decodes normally afterwards
    drive(1'b1, 32'h008000EF, 32'h114);
    tick();
    drive(1'b0, 32'h0, 32'h0);
    chk("jal_illegal",   64'(o_illegal), 64'd0);
    chk("jal_immsrc",    64'(o_immsrc), 64'd5);
    chk("jal_imm",       64'(o_imm), 64'd8);
    chk("jal_ctrl",      64'({o_regwrite, o_jump, o_alusrc, o_resultsrc}), 64'b11010);

    // lui x5,0x12345 and add x3,x1,x2
    drive(1'b1, 32'h123452B7, 32'h118);
    tick();
    chk("lui_imm",    64'(o_imm), 64'h12345000);
    chk("lui_immsrc", 64'(o_immsrc), 64'd4);
    drive(1'b1, 32'h002081B3, 32'h11C);
    tick();
    drive(1'b0, 32'h0, 32'h0);
    chk("r_immsrc", 64'(o_immsrc), 64'd3);
    chk("r_imm",    64'(o_imm), 64'd0);
    chk("r_ctrl",   64'({o_regwrite, o_alusrc, o_illegal}), 64'b100);
    tick();
    chk("drain_valid", 64'(o_valid), 64'd0);

    // Backpressure: three back-to-back offers with downstream stalled
    out_ready = 1'b0;
    drive(1'b1, 32'h00A00093, 32'h200);
    tick();
    chk("bp_ready_one", 64'(o_ready), 64'd1);
    drive(1'b1, 32'h01400113, 32'h204);
    tick();
    chk("bp_ready_two", 64'(o_ready), 64'd0);
    drive(1'b1, 32'h01E00193, 32'h208);
    tick();
    chk("bp_hold_ready", 64'(o_ready), 64'd0);
    chk("bp_hold_head",  64'(o_instr), 64'h00A00093);
    chk("bp_hold_imm",   64'(o_imm), 64'd10);
    out_ready = 1'b1;
    tick();
    chk("bp_ready_back", 64'(o_ready), 64'd1);
    chk("bp_head_b",     64'(o_instr), 64'h01400113);
    tick();
    drive(1'b0, 32'h0, 32'h0);
    chk("bp_head_c", 64'(o_instr), 64'h01E00193);
    chk("bp_imm_c",  64'(o_imm), 64'd30);
    tick();
    chk("bp_empty", 64'(o_valid), 64'd0);

    // Flush while full, with a same-cycle offer
    out_ready = 1'b0;
    drive(1'b1, 32'h00100093, 32'h300);
    tick();
    drive(1'b1, 32'h00200093, 32'h304);
    tick();
    chk("fl_full", 64'(o_ready), 64'd0);
    flush = 1'b1;
    out_ready = 1'b1;
    drive(1'b1, 32'h00300093, 32'h308);
    tick();
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    chk("fl_valid", 64'(o_valid), 64'd0);
    chk("fl_ready", 64'(o_ready), 64'd1);
    tick(); tick();
    chk("fl_nodrop_in", 64'(o_valid), 64'd0);

    // Reset in the middle of a full buffer
    out_ready = 1'b0;
    drive(1'b1, 32'h00400093, 32'h400);
    tick();
    drive(1'b1, 32'h00500093, 32'h404);
    tick();
    chk("mr_full", 64'(o_ready), 64'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    chk("mr_valid",  64'(o_valid), 64'd0);
    chk("mr_ready",  64'(o_ready), 64'd1);
    chk("mr_immsrc", 64'(o_immsrc), 64'd3);
    chk("mr_zero",   64'({o_imm, o_instr}), 64'd0);
    chk("mr_rest",   64'({o_pc, o_rd, o_rs1, o_rs2, o_funct3, o_regwrite, o_memwrite,
                          o_resultsrc, o_alusrc, o_branch, o_jump, o_illegal}), 64'd0);
    out_ready = 1'b1;
    drive(1'b1, 32'h00600093, 32'h500);
    tick();
    drive(1'b0, 32'h0, 32'h0);
    chk("mr_lat_valid", 64'(o_valid), 64'd1);
    chk("mr_lat_instr", 64'(o_instr), 64'h00600093);
    chk("mr_lat_pc",    64'(o_pc), 64'h500);
    tick(); tick();
    chk("end_empty", 64'(o_valid), 64'd0);
    chk("sb_drained", 64'(exp_q.size()), 64'd0);

    // Final report
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
